dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-port 16-bit data memory (8-bit address, 13 words, write on negedge clk, read while memread high).
- Shares the memory between port 0 (CPU load/store stage) and port 1 (loader/debug port) with round-robin priority.
- Drives the memory's memread, memwrt, addr and wd pins.
- Returns read data and a one-cycle ack to the winning requester.

Parameters:
- AW, 8, address width
- DW, 16, data width
- DEPTH, 13, number of implemented memory words (valid addresses 0..DEPTH-1)

Ports:
- clk  in  1  system clock; all state updates on posedge
- rst_n  in  1  synchronous active-low reset, sampled on posedge clk
- req0 / req1  in  1  access request; held high until matching ack
- we0 / we1  in  1  1 = write, 0 = read; stable while req high
- addr0 / addr1  in  AW  word address; stable while req high
- wdata0 / wdata1  in  DW  write data; stable while req high
- ack0 / ack1  out  1  one-cycle pulse; access complete
- rdata0 / rdata1  out  DW  read result, valid when ack high, held until the next ack on that port
- mem_read  out  1  to memory memread
- mem_wrt  out  1  to memory memwrt
- mem_addr  out  AW  to memory addr
- mem_wd  out  DW  to memory wd
- mem_rdata  in  DW  from memory readdata
- busy  out  1  high in ACCESS and DONE

Behaviour:
- Reset (rst_n low at posedge):
  - state = IDLE; ack0 = ack1 = 0; rdata0 = rdata1 = 0.
  - mem_read = mem_wrt = 0; mem_addr = 0; mem_wd = 0; busy = 0.
  - last_grant = 1, so port 0 wins the first tie.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, no req: stay; memory outputs hold address and data, with mem_read = mem_wrt = 0.
- IDLE, any req at posedge:
  - Pick winner: single requester wins; if both request, the port != last_grant wins.
  - Register winner, we, addr and wdata into the memory outputs.
  - mem_read = !we; mem_wrt = we; last_grant = winner; go to ACCESS.
- ACCESS (exactly 1 cycle):
  - Memory outputs stable for the whole cycle; the write commits at the mid-cycle negedge.
  - At the closing posedge: on a read, capture mem_rdata into rdata<winner>.
  - Pulse ack<winner> = 1; clear mem_read and mem_wrt; go to DONE.
- DONE (1 cycle):
  - ack high for exactly this cycle; the requester drops req in this cycle.
  - The DONE→IDLE posedge samples no requests.
  - Go to IDLE.
- Latency: request seen at posedge N → ack high in cycle N+2 → next grant no earlier than posedge N+3. Throughput is one access per 3 cycles.
- Losing requester keeps req high and is granted at the next IDLE; starvation is bounded to one access.
- Request dropped before ack is a protocol violation; the in-flight access still completes and acks.
- rst_n low during ACCESS or DONE: the access is abandoned, no ack is issued, and the FSM returns to IDLE. A write may already have committed at the negedge.
- Address above AW range is not possible; the DEPTH check applies only under the optional feature.

Optional Feature:
- Macro: DMEM_ARB_RANGE_CHK_EN.
- Defined:
  - Adds outputs err0 / err1 (1 bit, reset 0).
  - A granted access with addr >= DEPTH drives mem_read = mem_wrt = 0 during ACCESS, so memory is untouched.
  - rdata<winner> = 0; err<winner> pulses together with ack; FSM timing unchanged.
- Undefined:
  - No err ports; every address is passed to memory unchecked.

Decomposition:
- Package dmem_arb_pkg:
  - state encoding: IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2
  - AW_DEF = 8, DW_DEF = 16, DEPTH_DEF = 13
  - port index constants P0 = 1'b0, P1 = 1'b1
- Sub-module dmem_arb_pick: combinational 2-way round-robin picker (inputs req0, req1, last_grant; outputs valid, winner). Used only in IDLE.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles with req0 = 1 → all outputs 0, no ack; release → port 0 granted at the first posedge, ack0 two cycles later.
- Write then read on port 0:
  - write addr0 = 5, wdata0 = 16'hA5A5 → mem_wrt high for 1 cycle, ack0 at N+2.
  - read addr0 = 5 → rdata0 = 16'hA5A5 with ack0.
- Simultaneous req0 and req1, both held through 4 accesses → grant order 0,1,0,1; ack spacing exactly 3 cycles.
- Port 1 alone, read addr1 = 12 → ack1 only; ack0 stays 0; rdata0 unchanged.
- rst_n low during ACCESS → no ack; state IDLE; a pending req1 is granted at the first post-reset posedge.
- With DMEM_ARB_RANGE_CHK_EN, write addr0 = 13 → mem_wrt stays 0, ack0 and err0 pulse together, rdata0 = 0; memory word 12 unchanged.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared encodings and defaults for the two-port data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int AW_DEF    = 8;
  localparam int DW_DEF    = 16;
  localparam int DEPTH_DEF = 13;

  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational 2-way round-robin picker: on a tie the port that did not win last time is chosen.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic valid,
  output logic winner
);

  assign valid  = req0 | req1;
  assign winner = (req0 && req1) ? ~last_grant : (req1 ? P1 : P0);

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port data memory between two requesters.
// Optional address range check enabled by defining DMEM_ARB_RANGE_CHK_EN (adds err0/err1).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
`ifdef DMEM_ARB_RANGE_CHK_EN
  output logic          err0,
  output logic          err1,
`endif
  output logic          mem_read,
  output logic          mem_wrt,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  state_t        state_reg, state_next;
  logic          last_grant_reg, last_grant_next;
  logic          ack0_next, ack1_next;
  logic [DW-1:0] rdata0_next, rdata1_next;
  logic          mem_read_next, mem_wrt_next;
  logic [AW-1:0] mem_addr_next;
  logic [DW-1:0] mem_wd_next;

  logic          pick_valid, pick_winner;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  dmem_arb_pick u_pick (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant_reg),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  assign sel_we    = (pick_winner == P1) ? we1    : we0;
  assign sel_addr  = (pick_winner == P1) ? addr1  : addr0;
  assign sel_wdata = (pick_winner == P1) ? wdata1 : wdata0;
  assign busy      = (state_reg != IDLE);

`ifdef DMEM_ARB_RANGE_CHK_EN
  localparam logic [AW:0] DEPTH_LIM = DEPTH[AW:0];
  logic oob_reg, oob_next, sel_oob;
  logic err0_next, err1_next;
  assign sel_oob = ({1'b0, sel_addr} >= DEPTH_LIM);
`else
  // Without the range check DEPTH has no effect; an impossible depth simply elaborates nothing.
  if (DEPTH > (1 << AW)) begin : g_depth_exceeds_space
  end
`endif

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    ack0_next       = 1'b0;
    ack1_next       = 1'b0;
    rdata0_next     = rdata0;
    rdata1_next     = rdata1;
    mem_read_next   = mem_read;
    mem_wrt_next    = mem_wrt;
    mem_addr_next   = mem_addr;
    mem_wd_next     = mem_wd;
`ifdef DMEM_ARB_RANGE_CHK_EN
    oob_next        = oob_reg;
    err0_next       = 1'b0;
    err1_next       = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        mem_read_next = 1'b0;
        mem_wrt_next  = 1'b0;
        if (pick_valid) begin
          mem_addr_next   = sel_addr;
          mem_wd_next     = sel_wdata;
          mem_read_next   = !sel_we;
          mem_wrt_next    = sel_we;
          last_grant_next = pick_winner;
          state_next      = ACCESS;
`ifdef DMEM_ARB_RANGE_CHK_EN
          oob_next = sel_oob;
          if (sel_oob) begin
            mem_read_next = 1'b0;
            mem_wrt_next  = 1'b0;
          end
`endif
        end
      end
      ACCESS: begin
        // last_grant_reg holds the current winner for the whole access.
        ack0_next = (last_grant_reg == P0);
        ack1_next = (last_grant_reg == P1);
        if (mem_read) begin
          if (last_grant_reg == P1) rdata1_next = mem_rdata;
          else                      rdata0_next = mem_rdata;
        end
`ifdef DMEM_ARB_RANGE_CHK_EN
        if (oob_reg) begin
          if (last_grant_reg == P1) begin
            rdata1_next = '0;
            err1_next   = 1'b1;
          end else begin
            rdata0_next = '0;
            err0_next   = 1'b1;
          end
        end
`endif
        mem_read_next = 1'b0;
        mem_wrt_next  = 1'b0;
        state_next    = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      last_grant_reg <= P1;
      ack0           <= 1'b0;
      ack1           <= 1'b0;
      rdata0         <= '0;
      rdata1         <= '0;
      mem_read       <= 1'b0;
      mem_wrt        <= 1'b0;
      mem_addr       <= '0;
      mem_wd         <= '0;
`ifdef DMEM_ARB_RANGE_CHK_EN
      oob_reg        <= 1'b0;
      err0           <= 1'b0;
      err1           <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      ack0           <= ack0_next;
      ack1           <= ack1_next;
      rdata0         <= rdata0_next;
      rdata1         <= rdata1_next;
      mem_read       <= mem_read_next;
      mem_wrt        <= mem_wrt_next;
      mem_addr       <= mem_addr_next;
      mem_wd         <= mem_wd_next;
`ifdef DMEM_ARB_RANGE_CHK_EN
      oob_reg        <= oob_next;
      err0           <= err0_next;
      err1           <= err1_next;
`endif
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural 13-word memory (write on negedge).
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, we0, we1;
  logic [7:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        ack0, ack1;
  logic [15:0] rdata0, rdata1;
  logic        mem_read, mem_wrt;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wd, mem_rdata;
  logic        busy;
`ifdef DMEM_ARB_RANGE_CHK_EN
  logic        err0, err1;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] mem [0:12];

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_wrt && mem_addr < 8'd13) mem[mem_addr[3:0]] = mem_wd;
  end

  assign mem_rdata = (mem_read && mem_addr < 8'd13) ? mem[mem_addr[3:0]] : 16'h0000;

  dmem_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .req1      (req1),
    .we0       (we0),
    .we1       (we1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .ack0      (ack0),
    .ack1      (ack1),
    .rdata0    (rdata0),
    .rdata1    (rdata1),
`ifdef DMEM_ARB_RANGE_CHK_EN
    .err0      (err0),
    .err1      (err1),
`endif
    .mem_read  (mem_read),
    .mem_wrt   (mem_wrt),
    .mem_addr  (mem_addr),
    .mem_wd    (mem_wd),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-20s observed %h expected %h", tag, obs, exp);
  endtask

  task automatic set_req(input bit port, input bit r, input bit we, input logic [7:0] a,
                         input logic [15:0] wd);
    if (port) begin req1 = r; we1 = we; addr1 = a; wdata1 = wd; end
    else      begin req0 = r; we0 = we; addr0 = a; wdata0 = wd; end
  endtask

  // One complete access on a single port with exact cycle-by-cycle expectations.
  task automatic run_access(input string tag, input bit port, input bit we,
                            input logic [7:0] a, input logic [15:0] wd, input logic [15:0] exp_rd);
    set_req(port, 1'b1, we, a, wd);
    tick();
    check({tag, ".busy"}, 32'(busy), 32'd1);
    check({tag, ".mem_wrt"}, 32'(mem_wrt), 32'(we));
    check({tag, ".mem_read"}, 32'(mem_read), 32'(!we));
    check({tag, ".mem_addr"}, 32'(mem_addr), 32'(a));
    if (we) check({tag, ".mem_wd"}, 32'(mem_wd), 32'(wd));
    tick();
    check({tag, ".ack"}, {30'd0, ack1, ack0}, port ? 32'd2 : 32'd1);
    check({tag, ".wrt_clr"}, 32'(mem_wrt), 32'd0);
    if (!we) check({tag, ".rdata"}, 32'(port ? rdata1 : rdata0), 32'(exp_rd));
    set_req(port, 1'b0, 1'b0, 8'd0, 16'd0);
    tick();
    check({tag, ".idle"}, {29'd0, busy, ack1, ack0}, 32'd0);
  endtask

  int acks_seen;
  int ack_port [4];
  int ack_cyc  [4];

  initial begin
    for (int i = 0; i < 13; i++) mem[i] = 16'h1000 + 16'(i);
    rst_n = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'd0; wdata0 = 16'd0;
    req1 = 1'b0; we1 = 1'b0; addr1 = 8'd0; wdata1 = 16'd0;

    // Reset held 3 cycles with req0 pending.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst.ack", {30'd0, ack1, ack0}, 32'd0);
    end
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.mem_ctl", {30'd0, mem_read, mem_wrt}, 32'd0);
    check("rst.mem_addr", 32'(mem_addr), 32'd0);
    check("rst.mem_wd", 32'(mem_wd), 32'd0);
    check("rst.rdata", {rdata1, rdata0}, 32'd0);
    rst_n = 1'b1;
    run_access("post_rst_rd0", 1'b0, 1'b0, 8'd0, 16'd0, 16'h1000);

    run_access("wr0_a5", 1'b0, 1'b1, 8'd5, 16'hA5A5, 16'h0000);
    check("mem5_after_wr", 32'(mem[5]), 32'h0000A5A5);
    run_access("rd0_a5", 1'b0, 1'b0, 8'd5, 16'h0000, 16'hA5A5);

    // Request withdrawn right after the grant: access still completes.
    set_req(1'b0, 1'b1, 1'b0, 8'd12, 16'd0);
    tick();
    check("drop.busy", 32'(busy), 32'd1);
    set_req(1'b0, 1'b0, 1'b0, 8'd0, 16'd0);
    tick();
    check("drop.ack0", 32'(ack0), 32'd1);
    check("drop.rdata0", 32'(rdata0), 32'h0000100C);
    tick();

    // Port 1 alone; port 0 read data must stay put.
    run_access("rd1_a12", 1'b1, 1'b0, 8'd12, 16'h0000, 16'h100C);
    check("rd1.rdata0_kept", 32'(rdata0), 32'h0000100C);

    // Both ports request continuously: expect 0,1,0,1 with 3-cycle spacing.
    acks_seen = 0;
    set_req(1'b0, 1'b1, 1'b1, 8'd3, 16'hBEEF);
    set_req(1'b1, 1'b1, 1'b0, 8'd7, 16'h0000);
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (ack0 || ack1) begin
        check("rr.one_ack", {30'd0, ack1, ack0}, ack1 ? 32'd2 : 32'd1);
        if (ack1) check("rr.rdata1", 32'(rdata1), 32'h00001007);
        if (acks_seen < 4) begin
          ack_port[acks_seen] = ack1 ? 1 : 0;
          ack_cyc[acks_seen]  = c;
        end
        acks_seen++;
      end
    end
    set_req(1'b0, 1'b0, 1'b0, 8'd0, 16'd0);
    set_req(1'b1, 1'b0, 1'b0, 8'd0, 16'd0);
    check("rr.ack_count", 32'(acks_seen), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("rr.order", 32'(ack_port[i]), 32'(i % 2));
      check("rr.ack_cycle", 32'(ack_cyc[i]), 32'(2 + 3 * i));
    end
    check("rr.mem3", 32'(mem[3]), 32'h0000BEEF);
    tick();
    check("rr.idle", 32'(busy), 32'd0);

    // Reset during ACCESS: no ack, pending req1 granted right after release.
    set_req(1'b1, 1'b1, 1'b0, 8'd2, 16'd0);
    tick();
    check("rstacc.busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    check("rstacc.no_ack", {29'd0, busy, ack1, ack0}, 32'd0);
    check("rstacc.mem_read", 32'(mem_read), 32'd0);
    rst_n = 1'b1;
    tick();
    check("rstacc.regrant", {23'd0, busy, mem_read, mem_addr}, {23'd0, 1'b1, 1'b1, 8'd2});
    tick();
    check("rstacc.ack1", {30'd0, ack1, ack0}, 32'd2);
    check("rstacc.rdata1", 32'(rdata1), 32'h00001002);
    set_req(1'b1, 1'b0, 1'b0, 8'd0, 16'd0);
    tick();

    // Write to address 13 (one past the implemented words).
    set_req(1'b0, 1'b1, 1'b1, 8'd13, 16'h1234);
    tick();
`ifdef DMEM_ARB_RANGE_CHK_EN
    check("oob.mem_ctl", {30'd0, mem_read, mem_wrt}, 32'd0);
    tick();
    check("oob.ack_err0", {30'd0, err0, ack0}, 32'd3);
    check("oob.rdata0", 32'(rdata0), 32'd0);
`else
    check("oob.mem_wrt", 32'(mem_wrt), 32'd1);
    check("oob.mem_addr", 32'(mem_addr), 32'd13);
    tick();
    check("oob.ack0", 32'(ack0), 32'd1);
`endif
    check("oob.mem12", 32'(mem[12]), 32'h0000100C);
    set_req(1'b0, 1'b0, 1'b0, 8'd0, 16'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
